// File: rtl/pasta_pkg.sv
// rtl/pasta_pkg.sv - shared parameters and FSM state type for the PASTA keystream adder
package pasta_pkg;

    localparam int PASTA_BITLEN = 17;
    localparam int PASTA_Q      = 65537;
    localparam int PASTA_S      = 32;

    typedef enum logic [2:0] {
        IDLE,
        PERM_START,
        PERM_WAIT,
        STREAM,
        DRAIN
    } state_e;

endpackage

// File: rtl/pasta_mod_add_q.sv
// rtl/pasta_mod_add_q.sv - combinational (a + b) mod Q with a single conditional subtract
module pasta_mod_add_q
    import pasta_pkg::*;
#(
    parameter int BITLEN = PASTA_BITLEN,
    parameter int Q      = PASTA_Q
) (
    input  logic [BITLEN-1:0] a_i,
    input  logic [BITLEN-1:0] b_i,
    output logic [BITLEN-1:0] sum_o
);

    localparam logic [BITLEN:0]   QW = (BITLEN+1)'(Q);
    localparam logic [BITLEN-1:0] QL = QW[BITLEN-1:0];

    logic [BITLEN:0] raw;

    assign raw = {1'b0, a_i} + {1'b0, b_i};

    // Only the low BITLEN bits of the difference are kept, so subtracting the
    // truncated modulus gives the same result as the full-width subtract.
    assign sum_o = (raw >= QW) ? (raw[BITLEN-1:0] - QL) : raw[BITLEN-1:0];

endmodule

// File: rtl/pasta_keystream_add.sv
// rtl/pasta_keystream_add.sv - adds PASTA keystream elements to a plaintext word stream mod Q
module pasta_keystream_add
    import pasta_pkg::*;
#(
    parameter int BITLEN = PASTA_BITLEN,
    parameter int Q      = PASTA_Q,
    parameter int S      = PASTA_S
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [63:0]           nonce,
    input  logic [BITLEN-1:0]     pt_data,
    input  logic                  pt_valid,
    input  logic                  pt_last,
    output logic                  pt_ready,
    output logic [BITLEN-1:0]     ct_data,
    output logic                  ct_valid,
    output logic                  ct_last,
    input  logic                  ct_ready,
    output logic                  perm_rst,
    output logic [63:0]           perm_nonce,
    output logic [63:0]           perm_block_counter,
    input  logic [BITLEN*S-1:0]   perm_out_l,
    input  logic                  perm_done,
    output logic                  busy
);

    localparam int              IDXW     = (S > 1) ? $clog2(S) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(S - 1);

    state_e                state_q, state_d;
    logic [63:0]           nonce_q, nonce_d;
    logic [63:0]           bc_q, bc_d;
    logic [BITLEN*S-1:0]   ks_q, ks_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  wait_armed_q, wait_armed_d;
    logic [BITLEN-1:0]     ct_data_q, ct_data_d;
    logic                  ct_valid_q, ct_valid_d;
    logic                  ct_last_q, ct_last_d;

    logic [BITLEN-1:0]     ks_elem;
    logic [BITLEN-1:0]     sum_mod;
    logic                  pt_ready_c;
    logic                  perm_rst_c;
    logic                  pt_fire;

    assign ks_elem = ks_q[idx_q*BITLEN +: BITLEN];

    pasta_mod_add_q #(
        .BITLEN (BITLEN),
        .Q      (Q)
    ) u_mod_add (
        .a_i    (pt_data),
        .b_i    (ks_elem),
        .sum_o  (sum_mod)
    );

    always_comb begin
        state_d      = state_q;
        nonce_d      = nonce_q;
        bc_d         = bc_q;
        ks_d         = ks_q;
        idx_d        = idx_q;
        wait_armed_d = wait_armed_q;
        ct_data_d    = ct_data_q;
        ct_valid_d   = ct_valid_q;
        ct_last_d    = ct_last_q;
        pt_ready_c   = 1'b0;
        perm_rst_c   = 1'b0;
        pt_fire      = 1'b0;

        case (state_q)
            IDLE: begin
                perm_rst_c = 1'b1;
                if (start) begin
                    nonce_d = nonce;
                    bc_d    = '0;
                    state_d = PERM_START;
                end
            end
            PERM_START: begin
                perm_rst_c   = 1'b1;
                wait_armed_d = 1'b0;
                state_d      = PERM_WAIT;
            end
            PERM_WAIT: begin
                // The core's done flag may still be stale right after its reset.
                wait_armed_d = 1'b1;
                if (wait_armed_q && perm_done) begin
                    ks_d    = perm_out_l;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                pt_ready_c = !ct_valid_q || ct_ready;
                pt_fire    = pt_valid && pt_ready_c;
                if (pt_fire) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    if (pt_last) begin
                        state_d = DRAIN;
                    end else if (idx_q == IDX_LAST) begin
                        bc_d    = bc_q + 64'd1;
                        state_d = PERM_START;
                    end
                end
            end
            DRAIN: begin
                if (!ct_valid_q || ct_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output register drains in every state, so a block boundary never stalls it.
        if (pt_fire) begin
            ct_data_d  = sum_mod;
            ct_valid_d = 1'b1;
            ct_last_d  = pt_last;
        end else if (ct_ready) begin
            ct_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            nonce_q      <= '0;
            bc_q         <= '0;
            ks_q         <= '0;
            idx_q        <= '0;
            wait_armed_q <= 1'b0;
            ct_data_q    <= '0;
            ct_valid_q   <= 1'b0;
            ct_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nonce_q      <= nonce_d;
            bc_q         <= bc_d;
            ks_q         <= ks_d;
            idx_q        <= idx_d;
            wait_armed_q <= wait_armed_d;
            ct_data_q    <= ct_data_d;
            ct_valid_q   <= ct_valid_d;
            ct_last_q    <= ct_last_d;
        end
    end

    assign pt_ready           = pt_ready_c;
    assign perm_rst           = perm_rst_c;
    assign busy               = (state_q != IDLE);
    assign ct_data            = ct_data_q;
    assign ct_valid           = ct_valid_q;
    assign ct_last            = ct_last_q;
    assign perm_nonce         = nonce_q;
    assign perm_block_counter = bc_q;

endmodule

// File: tb/tb_pasta_keystream_add.sv
// tb/tb_pasta_keystream_add.sv - self-checking bench with a behavioural keystream-add model
module tb_pasta_keystream_add;

    localparam int BL = 17;
    localparam int QM = 65537;
    localparam int SS = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [63:0]       nonce = '0;
    logic [BL-1:0]     pt_data = '0;
    logic              pt_valid = 1'b0;
    logic              pt_last = 1'b0;
    logic              pt_ready;
    logic [BL-1:0]     ct_data;
    logic              ct_valid;
    logic              ct_last;
    logic              ct_ready = 1'b1;
    logic              perm_rst;
    logic [63:0]       perm_nonce;
    logic [63:0]       perm_block_counter;
    logic [BL*SS-1:0]  perm_out_l;
    logic              perm_done;
    logic              busy;

    always #5 clk = ~clk;

    pasta_keystream_add #(.BITLEN(BL), .Q(QM), .S(SS)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .nonce              (nonce),
        .pt_data            (pt_data),
        .pt_valid           (pt_valid),
        .pt_last            (pt_last),
        .pt_ready           (pt_ready),
        .ct_data            (ct_data),
        .ct_valid           (ct_valid),
        .ct_last            (ct_last),
        .ct_ready           (ct_ready),
        .perm_rst           (perm_rst),
        .perm_nonce         (perm_nonce),
        .perm_block_counter (perm_block_counter),
        .perm_out_l         (perm_out_l),
        .perm_done          (perm_done),
        .busy               (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Keystream source: 0 = all zero, 1 = all 65536, 2 = index/block/nonce dependent
    int ks_mode = 0;
    bit done_imm = 1'b0;
    int core_cnt = 0;
    int rdy_mode = 0;

    function automatic logic [BL-1:0] elem(input logic [63:0] blk, input int i,
                                           input logic [63:0] nn, input int mode);
        int v;
        if (mode == 0)      v = 0;
        else if (mode == 1) v = 65536;
        else                v = (i * 4099 + int'(blk[15:0]) * 811 + int'(nn[15:0])) % QM;
        return BL'(v);
    endfunction

    function automatic int madd(input int a, input int b);
        int s;
        s = a + b;
        if (s >= QM) s = s - QM;
        return s % (1 << BL);
    endfunction

    // Permutation core stand-in: data is garbage in the first cycle out of reset.
    always @(posedge clk) begin
        if (perm_rst) core_cnt <= 0;
        else if (core_cnt < 1000) core_cnt <= core_cnt + 1;
    end

    always_comb begin
        perm_done  = !perm_rst && (done_imm || core_cnt >= 3);
        perm_out_l = '1;
        if (!perm_rst && core_cnt >= 1) begin
            for (int i = 0; i < SS; i++)
                perm_out_l[i*BL +: BL] = elem(perm_block_counter, i, perm_nonce, ks_mode);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) ct_ready = 1'b1;
            else               ct_ready = ~ct_ready;
        end
    end

    logic [BL:0]   exp_q[$];
    logic [BL-1:0] rx[0:127];
    int            rx_n = 0;
    int            pulse_n = 0;
    logic [63:0]   pulse_bc[$];
    bit            mon_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [BL-1:0] prev_data;
    logic          prev_last;
    logic [BL:0]   e_pop;

    always @(negedge clk) begin
        if (!rst || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", ct_valid, 1);
                chk("stall_data", ct_data, prev_data);
                chk("stall_last", ct_last, prev_last);
            end
            if (ct_valid && ct_ready) begin
                if (exp_q.size() == 0) begin
                    chk("ct_unexpected", exp_q.size(), 1);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("ct_data", ct_data, e_pop[BL-1:0]);
                    chk("ct_last", ct_last, e_pop[BL]);
                end
                if (rx_n < 128) rx[rx_n] = ct_data;
                rx_n++;
            end
            if (busy && perm_rst) begin
                pulse_n++;
                pulse_bc.push_back(perm_block_counter);
            end
            prev_stall = ct_valid && !ct_ready;
            prev_data  = ct_data;
            prev_last  = ct_last;
        end
    end

    logic [BL-1:0] lit_pt[0:4];

    task automatic send_msg(input int n, input int pmode, input logic [63:0] nn, input int abort_at);
        int            to;
        int            e;
        logic [BL-1:0] p;
        rx_n = 0;
        pulse_n = 0;
        pulse_bc.delete();
        @(posedge clk); #1;
        start = 1'b1;
        nonce = nn;
        @(posedge clk); #1;
        start = 1'b0;
        nonce = '0;
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                pt_valid = 1'b0;
                pt_last  = 1'b0;
                return;
            end
            if (pmode == 0)      p = BL'(k);
            else if (pmode == 1) p = lit_pt[k];
            else                 p = BL'((k * 977 + 13) % QM);
            pt_valid = 1'b1;
            pt_data  = p;
            pt_last  = (k == n - 1);
            to = 0;
            @(negedge clk);
            while (!pt_ready && to < 300) begin
                @(negedge clk);
                to++;
            end
            if (!pt_ready) begin
                chk("pt_ready_timeout", pt_ready, 1);
                pt_valid = 1'b0;
                return;
            end
            if (rdy_mode == 0 && (k % SS) != 0) chk("throughput_stall", to, 0);
            e = madd(int'(p), int'(elem(k / SS, k % SS, nn, ks_mode)));
            exp_q.push_back({pt_last, BL'(e)});
            @(posedge clk); #1;
            chk("lat_valid", ct_valid, 1);
            chk("lat_data", ct_data, e);
        end
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        pt_data  = '0;
        to = 0;
        while (busy && to < 300) begin
            @(negedge clk);
            to++;
        end
        chk("busy_drop", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
        chk("ct_count", rx_n, n);
        chk("perm_pulses", pulse_n, (n + SS - 1) / SS);
        for (int j = 0; j < pulse_bc.size(); j++) chk("block_counter", pulse_bc[j], j);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ct_valid"}, ct_valid, 0);
        chk({tag, "_ct_last"}, ct_last, 0);
        chk({tag, "_ct_data"}, ct_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pt_ready"}, pt_ready, 0);
        chk({tag, "_perm_rst"}, perm_rst, 1);
        chk({tag, "_perm_nonce"}, perm_nonce, 0);
        chk({tag, "_perm_bc"}, perm_block_counter, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        lit_pt[0] = 17'd65536;
        lit_pt[1] = 17'd1;
        lit_pt[2] = 17'd0;
        lit_pt[3] = 17'd65535;
        lit_pt[4] = 17'd131071;

        #12;
        check_reset_outputs("reset");
        @(posedge clk); #3;
        rst = 1'b1;
        mon_en = 1'b1;

        // Keystream all 65536, five words including one out-of-contract value
        ks_mode = 1;
        send_msg(5, 1, 64'h1234, -1);
        chk("lit_req034", rx[0], 65535);
        chk("lit_wrap0", rx[1], 0);
        chk("lit_ks_only", rx[2], 65536);
        chk("lit_65534", rx[3], 65534);
        chk("lit_ooc", rx[4], 131070);

        // Zero keystream, 32-word identity block
        ks_mode = 0;
        send_msg(32, 0, 64'h0, -1);
        chk("lit_ident0", rx[0], 0);
        chk("lit_ident31", rx[31], 31);

        // Two blocks; core raises done immediately, data only valid a cycle later
        ks_mode = 2;
        done_imm = 1'b1;
        send_msg(40, 2, 64'hABCD_0005, -1);
        done_imm = 1'b0;
        chk("lit_blk0_w0", rx[0], 18);
        chk("lit_blk1_w33", rx[33], 37169);

        // Backpressure toggling every cycle
        rdy_mode = 1;
        send_msg(32, 2, 64'h77, -1);
        send_msg(33, 2, 64'h99, -1);
        rdy_mode = 0;

        // Reset after 10 words, then a fresh message
        send_msg(32, 2, 64'h55, 10);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        send_msg(40, 2, 64'h66, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pasta_keystream_add.md
PASTA_KEYSTREAM_ADD -- requirements
Module: pasta_keystream_add

Interface
REQ-001 SHALL have parameter BITLEN, default 17, element width in bits.
REQ-002 SHALL have parameter Q, default 65537, field modulus.
REQ-003 SHALL have parameter S, default 32, elements per keystream block.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (ports clk, rst).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a message; ignored while busy=1.
REQ-008 nonce  in  64  message nonce, sampled on accepted start.
REQ-009 pt_data, pt_valid, pt_last, pt_ready  in/in/in/out  BITLEN/1/1/1  plaintext word stream; pt_last marks the final word.
REQ-010 ct_data, ct_valid, ct_last, ct_ready  out/out/out/in  BITLEN/1/1/1  ciphertext word stream.
REQ-011 perm_rst  out  1  active-high synchronous reset to the permutation core.
REQ-012 perm_nonce, perm_block_counter  out/out  64/64  nonce and block counter driven to the permutation core.
REQ-013 perm_out_l, perm_done  in/in  BITLEN*S/1  permutation left-state output and completion flag.
REQ-014 busy  out  1  high from accepted start until the last ciphertext word is accepted.

Function
REQ-015 FSM states SHALL be IDLE, PERM_START, PERM_WAIT, STREAM, DRAIN.
REQ-016 IDLE: perm_rst=1, pt_ready=0; start -> latch nonce, block_counter=0, go PERM_START.
REQ-017 PERM_START: perm_rst=1 for exactly one cycle, then PERM_WAIT.
REQ-018 PERM_WAIT: perm_rst=0; perm_done SHALL be ignored in the first PERM_WAIT cycle; afterwards perm_done=1 -> latch perm_out_l into keystream register, idx=0, go STREAM.
REQ-019 Keystream element i SHALL be perm_out_l[BITLEN*i +: BITLEN], i=0..S-1.
REQ-020 STREAM: pt_ready = !ct_valid || ct_ready; a word transfers when pt_valid && pt_ready.
REQ-021 On transfer: ct_data <= (pt_data + ks[idx]) mod Q, computed as an (BITLEN+1)-bit sum minus Q once if sum >= Q; ct_valid <= 1; ct_last <= pt_last; idx++.
REQ-022 Latency: ct_data valid the cycle after pt transfer; full throughput of one word per cycle with ct_ready=1.
REQ-023 ct_valid SHALL clear on ct_ready unless a new word is transferred in the same cycle; ct_data/ct_last SHALL be stable while ct_valid && !ct_ready.
REQ-024 Transfer with pt_last=1 (any idx) -> DRAIN, regardless of idx.
REQ-025 Transfer at idx=S-1 with pt_last=0 -> block_counter+1, go PERM_START; ct output register continues to drain.
REQ-026 DRAIN: pt_ready=0; when ct_valid=0 or ct_ready=1 -> IDLE, busy=0.
REQ-027 pt_data >= Q is out of contract; single-subtract result SHALL still be produced, no error flag.
REQ-028 block_counter SHALL wrap 2^64-1 -> 0 silently.

Reset
REQ-029 rst=0 SHALL asynchronously force: state=IDLE, ct_valid=0, ct_last=0, ct_data=0, busy=0, pt_ready=0, idx=0, block_counter=0, perm_nonce=0, keystream=0, perm_rst=1.
REQ-030 Reset mid-message SHALL discard all in-flight words; operation resumes only on a new start.

Structure
REQ-031 pasta_pkg SHALL hold BITLEN, Q, S defaults and the FSM state enum.
REQ-032 One combinational sub-module pasta_mod_add_q SHALL implement the modular add of REQ-021.
REQ-033 The block SHALL connect directly to the existing permutation core outputs; no extra buffering of the keystream beyond one BITLEN*S register.

Verification
REQ-034 ks[0]=65536, pt=65536 -> ct_data=65535 one cycle after transfer.
REQ-035 ks all 0, pt 0..31 with pt_last on word 31 -> ct 0..31, ct_last on 32nd word only, busy drops after its acceptance.
REQ-036 40-word message -> perm_block_counter 0 then 1, two perm_rst pulses, 40 ct words, ct_last on word 40.
REQ-037 ct_ready toggled 1/0 every cycle on a 32-word block -> no word lost or duplicated, ct_data stable while stalled.
REQ-038 5-word message (pt_last on word 5) -> 5 ct words, no second perm_rst pulse, return to IDLE.
REQ-039 rst=0 asserted after 10 words of a block -> all outputs at REQ-029 values same cycle; subsequent start produces fresh block_counter=0.
